// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of a single RAM command bus.
// Optional WAIT-state abort timer enabled by defining ARB_TIMEOUT_EN.
module ram_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          mode0,
    input  logic          mode1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          done0,
    output logic          done1,
    output logic [DW-1:0] rdata,
    output logic          err,
    output logic [AW-1:0] ram_address,
    output logic [DW-1:0] ram_data,
    output logic          ram_mode,
    output logic          ram_start,
    input  logic [DW-1:0] ram_out,
    input  logic          ram_response
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t state, next_state;
    logic   last_grant;
    logic   gnt;
    logic   pick;
    logic   timed_out;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [CW-1:0] wait_cnt;
`endif

    always_comb begin
        next_state = state;
        pick       = 1'b0;
        timed_out  = 1'b0;
        case (state)
            IDLE: begin
                if (req0 && req1) pick = ~last_grant;
                else if (req1)    pick = 1'b1;
                if (req0 || req1) next_state = ISSUE;
            end
            ISSUE: next_state = WAIT;
            WAIT: begin
                if (ram_response) begin
                    next_state = DONE;
                end
`ifdef ARB_TIMEOUT_EN
                // Count reaches TIMEOUT on this edge; a coincident response wins.
                else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                    timed_out  = 1'b1;
                    next_state = DONE;
                end
`endif
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done0       <= 1'b0;
            done1       <= 1'b0;
            rdata       <= '0;
            ram_address <= '0;
            ram_data    <= '0;
            ram_mode    <= 1'b0;
            ram_start   <= 1'b0;
            gnt         <= 1'b0;
            last_grant  <= 1'b1;
        end else begin
            ram_start <= (state == IDLE) && (next_state == ISSUE);
            done0     <= (next_state == DONE) && !gnt;
            done1     <= (next_state == DONE) &&  gnt;
            if (state == IDLE && next_state == ISSUE) begin
                gnt         <= pick;
                ram_mode    <= pick ? mode1  : mode0;
                ram_address <= pick ? addr1  : addr0;
                ram_data    <= pick ? wdata1 : wdata0;
            end
            if (state == WAIT && ram_response && !ram_mode)
                rdata <= ram_out;
            if (state == DONE)
                last_grant <= gnt;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
            err      <= 1'b0;
        end else begin
            err <= timed_out;
            if (state == ISSUE)     wait_cnt <= '0;
            else if (state == WAIT) wait_cnt <= wait_cnt + CW'(1);
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: reset, read, stale pulses, input change,
// contention alternation, mid-operation reset and the WAIT timeout.
module tb_ram_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0, req1, mode0, mode1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          done0, done1, err;
    logic [DW-1:0] rdata;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_data;
    logic          ram_mode, ram_start;
    logic [DW-1:0] ram_out;
    logic          ram_response;

    int vectors = 0;
    int miscompares = 0;

    ram_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .mode0(mode0), .mode1(mode1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .done0(done0), .done1(done1), .rdata(rdata), .err(err),
        .ram_address(ram_address), .ram_data(ram_data), .ram_mode(ram_mode),
        .ram_start(ram_start), .ram_out(ram_out), .ram_response(ram_response)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start();
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ram_start) break;
        end
        check("start_seen", ram_start, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int ndone;
        rst = 1'b1;
        req0 = 0; req1 = 0; mode0 = 0; mode1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        ram_out = '0; ram_response = 0;

        // reset state and stale response in IDLE
        tick(); tick();
        check("rst_done0", done0, 0);
        check("rst_done1", done1, 0);
        check("rst_start", ram_start, 0);
        check("rst_rdata", rdata, 0);
        check("rst_addr", ram_address, 0);
        rst = 0;
        tick();
        ram_response = 1; ram_out = 32'h0BAD_0BAD;
        tick();
        ram_response = 0;
        tick();
        check("stale_done0", done0, 0);
        check("stale_done1", done1, 0);
        check("stale_rdata", rdata, 0);

        // single read on port 0, RAM answers 2 cycles after ram_start
        req0 = 1; mode0 = 0; addr0 = 32'h10;
        tick();
        check("rd_start", ram_start, 1);
        check("rd_mode", ram_mode, 0);
        check("rd_addr", ram_address, 32'h10);
        tick();
        check("rd_start_pulse", ram_start, 0);
        tick();
        ram_response = 1; ram_out = 32'hDEAD_BEEF;
        tick();
        ram_response = 0; req0 = 0;
        check("rd_done0", done0, 1);
        check("rd_done1", done1, 0);
        check("rd_rdata", rdata, 32'hDEAD_BEEF);
        tick();
        check("rd_done_once", done0, 0);

        // port 1 write; response during ISSUE ignored; addr change after grant
        req1 = 1; mode1 = 1; addr1 = 32'h20; wdata1 = 32'h77;
        wait_start();
        check("chg_addr", ram_address, 32'h20);
        ram_response = 1; ram_out = 32'h1111_1111;
        tick();
        ram_response = 0;
        addr1 = 32'h30;
        tick();
        check("issue_pulse_ignored", done1, 0);
        check("chg_addr_hold", ram_address, 32'h20);
        ram_response = 1;
        tick();
        ram_response = 0; req1 = 0;
        check("chg_done1", done1, 1);
        check("chg_done0", done0, 0);
        check("chg_addr_done", ram_address, 32'h20);
        check("wr_rdata_hold", rdata, 32'hDEAD_BEEF);

        // contention: both writes held, grants must alternate from port 0
        req0 = 1; req1 = 1; mode0 = 1; mode1 = 1;
        wdata0 = 32'hA; wdata1 = 32'hB;
        for (int i = 0; i < 4; i++) begin
            wait_start();
            check($sformatf("cont_data%0d", i), ram_data, (i % 2 == 0) ? 32'hA : 32'hB);
            check($sformatf("cont_mode%0d", i), ram_mode, 1);
            tick();
            ram_response = 1;
            tick();
            ram_response = 0;
            if (i == 3) begin req0 = 0; req1 = 0; end
            check($sformatf("cont_done0_%0d", i), done0, (i % 2 == 0) ? 1 : 0);
            check($sformatf("cont_done1_%0d", i), done1, (i % 2 == 0) ? 0 : 1);
        end
        tick();

        // asynchronous reset during WAIT
        req1 = 1; mode1 = 0; addr1 = 32'h40;
        wait_start();
        tick();
        #2 rst = 1;
        #1;
        check("mid_rst_start", ram_start, 0);
        check("mid_rst_addr", ram_address, 0);
        check("mid_rst_rdata", rdata, 0);
        check("mid_rst_done1", done1, 0);
        req1 = 0;
        tick();
        rst = 0; ram_response = 1; ram_out = 32'h55;
        tick();
        ram_response = 0;
        check("late_resp_done1", done1, 0);
        check("late_resp_rdata", rdata, 0);
        req1 = 1; mode1 = 0; addr1 = 32'h44;
        tick();
        check("fresh_start", ram_start, 1);
        tick();
        ram_response = 1; ram_out = 32'h1234_5678;
        tick();
        ram_response = 0; req1 = 0;
        check("fresh_done1", done1, 1);
        check("fresh_rdata", rdata, 32'h1234_5678);
        tick();

        // RAM never responds
        req0 = 1; mode0 = 0; addr0 = 32'h80;
        wait_start();
        tick();
`ifdef ARB_TIMEOUT_EN
        for (int i = 0; i < 7; i++) tick();
        check("to_early_done0", done0, 0);
        tick();
        req0 = 0;
        check("to_done0", done0, 1);
        check("to_err", err, 1);
        check("to_rdata", rdata, 32'h1234_5678);
        tick();
        check("to_err_pulse", err, 0);
`else
        ndone = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (done0 || done1) ndone++;
        end
        check("no_to_done", ndone, 0);
        check("no_to_err", err, 0);
        req0 = 0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
